// File: rtl/mem_stage_lsu_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu_pkg
// Shared types and helpers for the MEM-stage load/store unit.
//   lsu_state_t   : bus FSM states (IDLE -> WAIT -> DONE -> IDLE)
//   lsu_size_t    : access size (byte / halfword / word)
//   size_decode() : halfM/bM to lsu_size_t (byte wins when both are set)
//   lane_align()  : forces the low address bits to the natural alignment
//   is_misaligned(): true when the low address bits break natural alignment
//   be_gen()      : little-endian byte enables for an aligned lane
//   store_rep()   : replicates right-justified store data across the word
// ----------------------------------------------------------------------------
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;

  typedef enum {SZ_B, SZ_H, SZ_W} lsu_size_t;

  function automatic lsu_size_t size_decode(input logic half, input logic bsel);
    if (bsel)
      return SZ_B;
    else if (half)
      return SZ_H;
    return SZ_W;
  endfunction

  // Truncated alignment: a half keeps only addr[1], a word keeps nothing.
  function automatic logic [1:0] lane_align(input lsu_size_t size, input logic [1:0] lo);
    case (size)
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [3:0] be_gen(input lsu_size_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input lsu_size_t size, input logic [31:0] wd);
    case (size)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu_if
// Handshaked data-memory bus between the load/store unit and data memory.
//   req   : request, held until ack
//   we    : 1 = write
//   be    : byte enables (little-endian)
//   addr  : word-aligned byte address, ADDR_W bits
//   wdata : replicated store data
//   ack   : completes the request; rdata valid in the same cycle
//   rdata : read word
// Modports: master (load/store unit), slave (memory).
// ----------------------------------------------------------------------------
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Combinational load lane select and sign/zero extension.
//   i_rdata    : raw read word from memory
//   i_lane     : aligned byte offset of the access
//   i_size     : access size
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : 32-bit extended load value
// ----------------------------------------------------------------------------
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  lsu_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_lanes [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lanes[gi] = i_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_byte = w_lanes[i_lane];
    // Lane is already aligned for halves, so only lane[1] picks the pair.
    w_half = {w_lanes[{i_lane[1], 1'b1}], w_lanes[{i_lane[1], 1'b0}]};
    o_data = i_rdata;
    case (i_size)
      SZ_B:    o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
// Load/store unit of the MEM stage. Turns the M-stage access (aluoutM,
// writedataM, size controls) into one handshaked bus transaction, stalls the
// pipeline while it is outstanding and returns the extended load value.
//
// Parameters
//   ADDR_W      : bus byte-address width (<= 32)
//   TIMEOUT_CYC : WAIT cycles without ack before the access is aborted (>= 1)
//
// Ports
//   clk, reset  : clock; asynchronous active-low reset
//   memreadM/memwriteM/halfM/bM/bunsignedM : M-stage access controls
//   aluoutM     : effective byte address
//   writedataM  : right-justified store data
//   readdataM   : extended load data, valid while ldvalidM=1
//   ldvalidM    : load result valid (DONE cycle)
//   stallM      : hold F/D/E/M stages
//   misalignM   : 1-cycle pulse, misaligned access suppressed
//   buserrM     : 1-cycle pulse, ack timeout
//   dmem        : data-memory bus (mem_stage_lsu_if.master)
//
// Build option: define LSU_MISALIGN_TRAP_EN to suppress misaligned halves
// and words (misalignM pulse, no request, no stall). Without it misalignM is
// tied 0 and the offending low address bits are truncated to alignment.
// ----------------------------------------------------------------------------
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic        halfM,
  input  logic        bM,
  input  logic        bunsignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        ldvalidM,
  output logic        stallM,
  output logic        misalignM,
  output logic        buserrM,
  mem_stage_lsu_if.master dmem
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  TMO_VAL = CNT_W'(TIMEOUT_CYC);

  // --------------------------------------------------------------------------
  // M-stage decode (access cycle)
  // --------------------------------------------------------------------------
  lsu_size_t         w_size;
  logic [1:0]        w_lane;
  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_access;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_addr;

  assign w_size   = size_decode(halfM, bM);
  assign w_lane   = lane_align(w_size, aluoutM[1:0]);
  assign w_mem_op = memreadM | memwriteM;
  assign w_be     = be_gen(w_size, w_lane);
  assign w_wdata  = store_rep(w_size, writedataM);
  assign w_addr   = {aluoutM[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = is_misaligned(w_size, aluoutM[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // Gating with reset keeps every combinational output low while reset is
  // held, even if the M-stage still presents an access.
  assign w_access = reset & w_mem_op & ~w_misaligned;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  lsu_state_t        r_state;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_lane;
  lsu_size_t         r_size;
  logic              r_unsigned;
  logic              r_is_load;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_ldvalid;
  logic              r_buserr;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic [31:0]       w_ld_data;

  assign w_cnt_inc = r_cnt + 1'b1;

  lsu_load_align u_load_align (
    .i_rdata    (dmem.rdata),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_lane     <= '0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_is_load  <= 1'b0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_ldvalid  <= 1'b0;
      r_buserr   <= 1'b0;
    end else begin
      r_buserr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            // Snapshot the access so the bus stays stable through WAIT.
            r_state    <= WAIT;
            r_we       <= memwriteM;
            r_be       <= w_be;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_lane     <= w_lane;
            r_size     <= w_size;
            r_unsigned <= bunsignedM;
            r_is_load  <= memreadM & ~memwriteM;
            r_cnt      <= '0;
          end
        end
        WAIT: begin
          r_cnt <= w_cnt_inc;
          // An ack in the last allowed cycle still completes normally.
          if (dmem.ack) begin
            r_state <= DONE;
            if (r_is_load) begin
              r_rdata   <= w_ld_data;
              r_ldvalid <= 1'b1;
            end
          end else if (w_cnt_inc == TMO_VAL) begin
            r_state  <= DONE;
            r_buserr <= 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_ldvalid <= 1'b0;
          r_rdata   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus drive: live M-stage values in the access cycle, snapshot in WAIT.
  // --------------------------------------------------------------------------
  always_comb begin
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.be    = '0;
    dmem.addr  = '0;
    dmem.wdata = '0;
    if (r_state == WAIT) begin
      dmem.req   = 1'b1;
      dmem.we    = r_we;
      dmem.be    = r_be;
      dmem.addr  = r_addr;
      dmem.wdata = r_wdata;
    end else if ((r_state == IDLE) && w_access) begin
      dmem.req   = 1'b1;
      dmem.we    = memwriteM;
      dmem.be    = w_be;
      dmem.addr  = w_addr;
      dmem.wdata = w_wdata;
    end
  end

  // DONE releases the stall so the pipeline advances exactly once per access.
  assign stallM    = (r_state == WAIT) | ((r_state == IDLE) & w_access);
  assign readdataM = r_rdata;
  assign ldvalidM  = r_ldvalid;
  assign buserrM   = r_buserr;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalignM = reset & (r_state == IDLE) & w_mem_op & w_misaligned;
`else
  assign misalignM = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int TMO = 12;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memreadM = 1'b0, memwriteM = 1'b0, halfM = 1'b0, bM = 1'b0, bunsignedM = 1'b0;
  logic [31:0] aluoutM = '0, writedataM = '0;
  logic [31:0] readdataM;
  logic        ldvalidM, stallM, misalignM, buserrM;

  mem_stage_lsu_if #(.ADDR_W(32)) dmem_bus ();

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .halfM      (halfM),
    .bM         (bM),
    .bunsignedM (bunsignedM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .ldvalidM   (ldvalidM),
    .stallM     (stallM),
    .misalignM  (misalignM),
    .buserrM    (buserrM),
    .dmem       (dmem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    bit          misal;
    bit          ld;
    logic [31:0] rdata;
    bit          berr;
    int          stall;
  } done_exp_t;

  req_exp_t    req_q[$];
  done_exp_t   done_q[$];
  int          total = 0;
  int          bad = 0;
  int          cur_delay = -1;
  logic [31:0] cur_rdata = '0;
  int          txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: size in bytes, natural alignment by truncation,
  // byte-replicated store data, shifted/masked/extended load data.
  function automatic void model(input bit h, input bit b, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdat, input bit u,
                                output logic [3:0] be, output logic [31:0] wdata,
                                output logic [31:0] ld, output bit mis);
    int nb;
    int off;
    logic [31:0] mask;
    nb   = b ? 1 : (h ? 2 : 4);
    off  = int'(a[1:0]);
    mis  = (off % nb) != 0;
    off  = off - (off % nb);
    be   = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
    ld   = (rdat >> (8*off)) & mask;
    if (!u && nb < 4 && ld[8*nb-1]) ld = ld | ~mask;
  endfunction

  // Memory responder: ack in req cycle dly+1 (cycle 1 is the access cycle);
  // ack toggles randomly whenever the LSU cannot legally consume it.
  initial begin : responder
    int req_cyc;
    req_cyc = 0;
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (reset && dmem_bus.req) begin
        req_cyc++;
        if (cur_delay >= 1 && req_cyc == cur_delay + 1) begin
          dmem_bus.ack   = 1'b1;
          dmem_bus.rdata = cur_rdata;
        end else begin
          dmem_bus.ack   = (req_cyc == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          dmem_bus.rdata = $urandom;
        end
      end else begin
        req_cyc        = 0;
        dmem_bus.ack   = 1'($urandom_range(0, 1));
        dmem_bus.rdata = $urandom;
      end
    end
  end

  // Monitor: pops request expectations on each new request and completion
  // expectations on DONE (end of a stall run) or on a misalign pulse.
  initial begin : monitor
    int        run;
    bit        prev_req;
    bit        have_cur;
    req_exp_t  cur;
    done_exp_t e;
    run = 0; prev_req = 0; have_cur = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0; prev_req = 0; have_cur = 0;
      end else begin
        if (dmem_bus.req) begin
          if (!prev_req) begin
            if (req_q.size() == 0) begin
              total++; bad++; have_cur = 0;
              $display("FAIL req_unexpected: got req=1 want no request (t=%0t)", $time);
            end else begin
              cur = req_q.pop_front();
              have_cur = 1;
            end
          end
          if (have_cur) begin
            check("req_we", 32'(dmem_bus.we), 32'(cur.we));
            check("req_be", 32'(dmem_bus.be), 32'(cur.be));
            check("req_addr", dmem_bus.addr, cur.addr);
            if (cur.we) check("req_wdata", dmem_bus.wdata, cur.wdata);
          end
        end else begin
          have_cur = 0;
        end
        prev_req = dmem_bus.req;

        if (misalignM) begin
          if (done_q.size() == 0) begin
            total++; bad++;
            $display("FAIL misal_unexpected: got misalignM=1 want 0 (t=%0t)", $time);
          end else begin
            e = done_q.pop_front();
            check("misal_expected", 32'(misalignM), 32'(e.misal));
            check("misal_stall", 32'(stallM), 32'd0);
          end
        end

        if (stallM) begin
          run++;
        end else if (run > 0) begin
          if (done_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got completion want none (t=%0t)", $time);
          end else begin
            e = done_q.pop_front();
            check("done_not_misal", 32'(e.misal), 32'd0);
            check("done_stall_cycles", 32'(run), 32'(e.stall));
            check("done_ldvalid", 32'(ldvalidM), 32'(e.ld && !e.berr));
            check("done_buserr", 32'(buserrM), 32'(e.berr));
            if (e.ld || e.berr) check("done_readdata", readdataM, e.rdata);
          end
          run = 0;
        end else if (ldvalidM || buserrM) begin
          total++; bad++;
          $display("FAIL spurious_status: got ldvalid=%0b buserr=%0b want 0 0 (t=%0t)",
                   ldvalidM, buserrM, $time);
        end
      end
    end
  end

  // Issue one M-stage instruction (called just after a rising edge) and hold
  // it until the pipeline advances.
  task automatic issue(input bit rd, input bit wr, input bit h, input bit b, input bit u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int dly);
    logic [3:0]  be;
    logic [31:0] wdx, ld;
    bit          mis, to;
    req_exp_t    r;
    done_exp_t   d;
    int          n;
    model(h, b, a, wd, rdat, u, be, wdx, ld, mis);
    to = (dly < 1) || (dly > TMO);
    if (rd || wr) begin
      if (TRAP && mis) begin
        d.misal = 1; d.ld = 0; d.rdata = '0; d.berr = 0; d.stall = 0;
        done_q.push_back(d);
      end else begin
        r.we = wr; r.be = be; r.addr = {a[31:2], 2'b00}; r.wdata = wdx;
        req_q.push_back(r);
        d.misal = 0;
        d.ld    = rd && !wr;
        d.rdata = (d.ld && !to) ? ld : 32'h0;
        d.berr  = to;
        d.stall = to ? TMO + 1 : dly + 1;
        done_q.push_back(d);
      end
    end
    cur_delay = dly; cur_rdata = rdat;
    memreadM = rd; memwriteM = wr; halfM = h; bM = b; bunsignedM = u;
    aluoutM = a; writedataM = wd;
    txn++;
    $display("txn %0d rd=%0b wr=%0b h=%0b b=%0b u=%0b addr=0x%08h wd=0x%08h rdata=0x%08h dly=%0d",
             txn, rd, wr, h, b, u, a, wd, rdat, dly);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!stallM) break;
      if (n > 4 * TMO + 50) begin
        total++; bad++;
        $display("FAIL stall_bound: got stall for %0d cycles want release", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    memreadM = 1'b0; memwriteM = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int sel, dly;
    // Reset with an access presented: everything must stay quiet.
    memreadM = 1'b1; memwriteM = 1'b1; aluoutM = 32'h0000_1234; writedataM = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dmem_bus.req), 32'd0);
    check("rst_stall", 32'(stallM), 32'd0);
    check("rst_ldvalid", 32'(ldvalidM), 32'd0);
    check("rst_buserr", 32'(buserrM), 32'd0);
    check("rst_misalign", 32'(misalignM), 32'd0);
    check("rst_readdata", readdataM, 32'd0);
    check("rst_be", 32'(dmem_bus.be), 32'd0);
    check("rst_addr", dmem_bus.addr, 32'd0);
    memreadM = 1'b0; memwriteM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases
    issue(1, 0, 0, 1, 0, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 1);   // lb
    issue(1, 0, 1, 0, 1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3);   // lhu
    issue(0, 1, 0, 1, 0, 32'h0000_0011, 32'h0000_00A5, $urandom, 2); // sb
    issue(0, 1, 0, 0, 0, 32'h0000_0004, $urandom, $urandom, -1);     // sw, timeout
    issue(1, 0, 0, 0, 0, 32'h0000_0006, 32'h0, 32'h1122_3344, 1);    // lw misaligned
    issue(1, 0, 1, 0, 0, 32'h0000_3002, 32'h0, 32'h8001_7FFF, TMO);  // ack on last cycle
    issue(1, 1, 1, 0, 0, 32'h0000_0042, 32'h0000_C3D2, $urandom, 2); // rd+wr -> store
    issue(1, 0, 1, 0, 0, 32'h0000_0003, 32'h0, 32'hF0E1_D2C3, 2);    // lh misaligned

    // Asynchronous reset in the middle of WAIT
    begin
      req_exp_t r;
      r.we = 1'b1; r.be = 4'b1111; r.addr = 32'h0000_0100; r.wdata = 32'h1234_5678;
      req_q.push_back(r);
      cur_delay = -1;
      memwriteM = 1'b1; halfM = 1'b0; bM = 1'b0; aluoutM = 32'h0000_0100;
      writedataM = 32'h1234_5678;
      txn++;
      $display("txn %0d sw addr=0x00000100 with reset in WAIT", txn);
      @(negedge clk); @(negedge clk);
      check("wait_stall_before_reset", 32'(stallM), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_req", 32'(dmem_bus.req), 32'd0);
      check("async_rst_stall", 32'(stallM), 32'd0);
      memwriteM = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
    end
    issue(1, 0, 0, 1, 1, 32'h0000_0201, 32'h0, 32'h0000_9A00, 1);    // lbu after reset

    // Randomised traffic
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 19);
      dly = (sel == 0) ? -1 : ((sel == 1) ? TMO : $urandom_range(1, 4));
      sel = $urandom_range(0, 9);
      issue(sel >= 1 && sel <= 4 || sel == 9, sel >= 5, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, dly);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
